contador_sync: RTL and testbench



---
 rtl/contador_sync.sv | 43 ++++
 tb/tb_contador_sync.sv | 114 +++++++++++
 2 files changed

// File: rtl/contador_sync.sv
// Free-running up-counter with a runtime terminal value; fim flags the terminal count.
// Define CONTADOR_SYNC_SATURATE_EN to make the counter hold at the terminal value instead of wrapping.
module contador_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] valor_maximo,
    output logic [WIDTH-1:0] contagem,
    output logic             fim
);

    logic [WIDTH-1:0] r_contagem;
    logic [WIDTH-1:0] w_proximo;
    logic             w_fim;

    // A terminal value lowered below the count is treated as terminal too,
    // so the increment below can never carry out of WIDTH bits.
    assign w_fim = (r_contagem >= valor_maximo);

    always_comb begin
        w_proximo = r_contagem + WIDTH'(1);
        if (w_fim) begin
`ifdef CONTADOR_SYNC_SATURATE_EN
            w_proximo = r_contagem;
`else
            w_proximo = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else begin
            r_contagem <= w_proximo;
        end
    end

    assign contagem = r_contagem;
    assign fim      = w_fim;

endmodule

// File: tb/tb_contador_sync.sv
// Directed bench for contador_sync (default wrap build): reset, wrap, short period,
// terminal value zero, lowering/raising the terminal value and async reset mid-count.
module tb_contador_sync;

    logic       clk;
    logic       reset;
    logic [4:0] valor_maximo;
    logic [4:0] contagem;
    logic       fim;

    int checks = 0;
    int errors = 0;

    contador_sync #(.WIDTH(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .valor_maximo (valor_maximo),
        .contagem     (contagem),
        .fim          (fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        valor_maximo = 5'd31;
        #2;
        chk("reset_cont", 32'(contagem), 0);
        chk("reset_fim", 32'(fim), 0);
        @(negedge clk);
        chk("reset_hold_cont", 32'(contagem), 0);
        reset = 1'b0;

        // full range: 0..31,0..31,0..11 after release
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            chk("wrap31_cont", 32'(contagem), 32'(k % 32));
            chk("wrap31_fim", 32'(fim), 32'((k % 32) == 31));
        end

        // count is 11 here; lowering to 4 is immediately terminal
        valor_maximo = 5'd4;
        #1;
        chk("low4_fim_now", 32'(fim), 1);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            chk("per5_cont", 32'(contagem), 32'((j - 1) % 5));
            chk("per5_fim", 32'(fim), 32'(((j - 1) % 5) == 4));
        end

        // count is 4; terminal value zero pins the counter at 0
        valor_maximo = 5'd0;
        #1;
        chk("max0_fim_now", 32'(fim), 1);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("max0_cont", 32'(contagem), 0);
            chk("max0_fim", 32'(fim), 1);
        end

        valor_maximo = 5'd31;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk("up12_cont", 32'(contagem), 32'(j));
            chk("up12_fim", 32'(fim), 0);
        end

        // lower 31 -> 5 while count is 12
        valor_maximo = 5'd5;
        #1;
        chk("low5_fim_now", 32'(fim), 1);
        chk("low5_cont_now", 32'(contagem), 12);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk("per6_cont", 32'(contagem), 32'((j - 1) % 6));
            chk("per6_fim", 32'(fim), 32'(((j - 1) % 6) == 5));
        end

        // count is 5; raising the terminal value continues without restart
        valor_maximo = 5'd31;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk("raise_cont", 32'(contagem), 32'(5 + j));
            chk("raise_fim", 32'(fim), 0);
        end
        chk("at17_cont", 32'(contagem), 17);

        // async reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_cont", 32'(contagem), 0);
        chk("async_rst_fim", 32'(fim), 0);
        @(negedge clk);
        chk("async_hold_cont", 32'(contagem), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cont", 32'(contagem), 1);
        chk("post_rst_fim", 32'(fim), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
